// File: rtl/bash_hash_loader.sv
// bash_hash_loader: packs a byte-granular 64-bit word stream into rate-sized
// blocks, applies bash-hash padding (0x40 then zeros, plus a pad-only block
// when the message ends on a block boundary) and sequences the control unit.
module bash_hash_loader #(
    parameter int RATE_WORDS = 16,
    parameter int CNT_W      = $clog2(RATE_WORDS + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [63:0]             msg_data_i,
    input  logic                    msg_valid_i,
    input  logic                    msg_last_i,
    input  logic [2:0]              msg_bytes_i,
    output logic                    msg_ready_o,
    output logic [64*RATE_WORDS-1:0] blk_data_o,
    output logic                    blk_last_o,
    output logic                    prep_active_o,
    output logic                    start_active_o,
    input  logic                    cu_rdy_i,
    output logic                    done_o
);

    typedef enum logic [1:0] {IDLE, FILL, ISSUE, WAIT_CU} state_t;

    state_t                          state_q;
    logic [CNT_W-1:0]                wcnt_q;
    logic                            pad_pending_q;
    logic                            final_q;
    logic [RATE_WORDS-1:0][63:0]     blk_q;

    logic                            accept;
    logic                            at_end;
    logic                            last_partial;
    logic                            last_full;
    logic [63:0]                     wr_word;

    // Keep bytes below b, put the 0x40 marker at byte b, zero everything above.
    function automatic logic [63:0] pad_word(input logic [63:0] d, input logic [2:0] b);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < int'(b))
                r[8*k +: 8] = d[8*k +: 8];
            else if (k == int'(b))
                r[8*k +: 8] = 8'h40;
        end
        return r;
    endfunction

    assign msg_ready_o    = (state_q == FILL) && cu_rdy_i;
    assign accept         = msg_ready_o && msg_valid_i;
    assign at_end         = (wcnt_q == CNT_W'(RATE_WORDS - 1));
    assign last_partial   = msg_last_i && (msg_bytes_i != 3'd0);
    assign last_full      = msg_last_i && (msg_bytes_i == 3'd0);
    assign wr_word        = last_partial ? pad_word(msg_data_i, msg_bytes_i) : msg_data_i;

    // Requests are decoded from state so they line up exactly with the FSM.
    assign prep_active_o  = (state_q == IDLE) && msg_valid_i;
    assign start_active_o = (state_q == ISSUE);
    assign done_o         = (state_q == WAIT_CU) && cu_rdy_i && final_q;
    assign blk_last_o     = final_q;
    assign blk_data_o     = blk_q;

    // Loader FSM: fill slots, pad on the last word, issue, wait for the control unit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            wcnt_q        <= '0;
            pad_pending_q <= 1'b0;
            final_q       <= 1'b0;
            blk_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Word stays on the bus; it is taken once the state is initialised.
                    if (msg_valid_i)
                        state_q <= FILL;
                end
                FILL: begin
                    if (accept) begin
                        wcnt_q <= wcnt_q + CNT_W'(1);
                        for (int i = 0; i < RATE_WORDS; i++) begin
                            if (wcnt_q == CNT_W'(i))
                                blk_q[i] <= wr_word;
                            // Full last word with room left: marker goes in the next slot.
                            if (i > 0 && last_full && !at_end && wcnt_q == CNT_W'(i - 1))
                                blk_q[i] <= 64'h40;
                        end
                        if (msg_last_i) begin
                            if (last_full && at_end)
                                pad_pending_q <= 1'b1;
                            else
                                final_q <= 1'b1;
                            state_q <= ISSUE;
                        end else if (at_end) begin
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    wcnt_q  <= '0;
                    state_q <= WAIT_CU;
                end
                WAIT_CU: begin
                    // Buffer stays frozen until the permutation has consumed it.
                    if (cu_rdy_i) begin
                        blk_q <= '0;
                        if (final_q) begin
                            final_q <= 1'b0;
                            state_q <= IDLE;
                        end else if (pad_pending_q) begin
                            blk_q[0]      <= 64'h40;
                            final_q       <= 1'b1;
                            pad_pending_q <= 1'b0;
                            state_q       <= ISSUE;
                        end else begin
                            state_q <= FILL;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bash_hash_loader.sv
// Testbench for bash_hash_loader: a byte-stream padding model fills a
// scoreboard of expected blocks, a monitor pops and compares them on each start.
module tb_bash_hash_loader;
    localparam int R  = 16;
    localparam int NB = 8 * R;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [63:0]      msg_data = '0;
    logic             msg_valid = 1'b0;
    logic             msg_last = 1'b0;
    logic [2:0]       msg_bytes = '0;
    logic             msg_ready;
    logic [64*R-1:0]  blk_data;
    logic             blk_last, prep, start, done, cu_rdy;

    int  cu_busy = 0;
    int  cu_lat  = 4;
    int  n_tests = 0, n_fail = 0;
    int  n_start = 0, n_done = 0, n_prep = 0;
    bit  in_wait = 0, chk_zero = 0;

    typedef struct { logic [64*R-1:0] data; logic last; } blk_t;
    blk_t            sb[$];
    logic [64*R-1:0] obs[$];
    logic [63:0]     msg[$];

    always #5 clk = ~clk;

    assign cu_rdy = (cu_busy == 0);

    bash_hash_loader #(.RATE_WORDS(R)) dut (
        .clk_i(clk), .rst_i(rst),
        .msg_data_i(msg_data), .msg_valid_i(msg_valid), .msg_last_i(msg_last),
        .msg_bytes_i(msg_bytes), .msg_ready_o(msg_ready),
        .blk_data_o(blk_data), .blk_last_o(blk_last),
        .prep_active_o(prep), .start_active_o(start),
        .cu_rdy_i(cu_rdy), .done_o(done)
    );

    // Control unit model: busy for cu_lat cycles after each start.
    always @(posedge clk) begin
        if (rst)              cu_busy <= 0;
        else if (start)       cu_busy <= cu_lat;
        else if (cu_busy > 0) cu_busy <= cu_busy - 1;
    end

    // Monitor / scoreboard consumer.
    always @(negedge clk) begin
        blk_t e;
        if (rst) begin
            in_wait  = 0;
            chk_zero = 0;
        end else begin
            n_tests++;
            if (int'(prep) + int'(start) + int'(done) > 1) begin
                n_fail++;
                $display("FAIL excl: prep=%b start=%b done=%b", prep, start, done);
            end
            if (prep) n_prep++;
            if (chk_zero) begin
                chk_zero = 0;
                n_tests++;
                if (blk_data !== '0 || blk_last !== 1'b0) begin
                    n_fail++;
                    $display("FAIL zero_after_done: blk_data nonzero=%b last=%b, want 0/0", |blk_data, blk_last);
                end
            end
            if (done) begin
                n_done++;
                chk_zero = 1;
                n_tests++;
                if (blk_last !== 1'b1) begin
                    n_fail++;
                    $display("FAIL last_at_done: blk_last=%b want 1", blk_last);
                end
            end
            if (in_wait && !start) begin
                n_tests++;
                if (msg_ready !== 1'b0 || blk_data !== obs[$]) begin
                    n_fail++;
                    $display("FAIL wait_hold: ready=%b data_stable=%b, want 0/1", msg_ready, blk_data === obs[$]);
                end
                if (cu_rdy) in_wait = 0;
            end
            if (start) begin
                n_start++;
                in_wait = 1;
                obs.push_back(blk_data);
                n_tests++;
                if (msg_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL issue_ready: ready=%b want 0", msg_ready);
                end
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_start: start=1 with no block expected");
                end else begin
                    e = sb.pop_front();
                    if (blk_data !== e.data || blk_last !== e.last) begin
                        n_fail++;
                        $display("FAIL block: got w0=%h w1=%h last=%b, want w0=%h w1=%h last=%b",
                                 blk_data[63:0], blk_data[127:64], blk_last,
                                 e.data[63:0], e.data[127:64], e.last);
                    end
                end
            end
        end
    end

    // Padding model over a byte stream: pad to ceil((L+1)/NB) blocks.
    task automatic push_expected(input int b, output int nblk);
        byte unsigned q[$];
        blk_t e;
        int L;
        L = (msg.size() - 1) * 8 + ((b == 0) ? 8 : b);
        for (int i = 0; i < L; i++) q.push_back(msg[i/8][8*(i%8) +: 8]);
        q.push_back(8'h40);
        while (q.size() % NB != 0) q.push_back(8'h00);
        nblk = q.size() / NB;
        for (int k = 0; k < nblk; k++) begin
            e.data = '0;
            for (int j = 0; j < NB; j++) e.data[8*j +: 8] = q[k*NB + j];
            e.last = (k == nblk - 1);
            sb.push_back(e);
        end
    endtask

    // Drive msg[] with valid held high between words; last word carries b.
    task automatic send_msg(input int b);
        for (int i = 0; i < msg.size(); i++) begin
            int t;
            t = 0;
            msg_data  = msg[i];
            msg_valid = 1'b1;
            msg_last  = (i == msg.size() - 1);
            msg_bytes = msg_last ? b[2:0] : 3'($urandom);
            do begin @(negedge clk); t++; end while (!msg_ready && t < 500);
            if (!msg_ready) begin
                n_tests++; n_fail++;
                $display("FAIL accept_timeout: word %0d ready=%b want 1", i, msg_ready);
                msg_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        msg_valid = 1'b0;
        msg_last  = 1'b0;
    endtask

    task automatic run_msg(input int b, input int lat);
        int nblk, s0, d0, p0, t;
        cu_lat = lat;
        obs.delete();
        push_expected(b, nblk);
        s0 = n_start; d0 = n_done; p0 = n_prep;
        send_msg(b);
        t = 0;
        while (n_done == d0 && t < 2000) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        n_tests++;
        if (n_done - d0 != 1) begin
            n_fail++; $display("FAIL done_count: got %0d want 1", n_done - d0);
        end
        n_tests++;
        if (n_start - s0 != nblk) begin
            n_fail++; $display("FAIL start_count: got %0d want %0d", n_start - s0, nblk);
        end
        n_tests++;
        if (n_prep - p0 != 1) begin
            n_fail++; $display("FAIL prep_count: got %0d want 1", n_prep - p0);
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_left: %0d blocks never issued, want 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if ({msg_ready, prep, start, done, blk_last} !== 5'b0 || blk_data !== '0) begin
                n_fail++;
                $display("FAIL reset_idle: ready/prep/start/done/last=%b data_nz=%b want 0", {msg_ready, prep, start, done, blk_last}, |blk_data);
            end
        end
    endtask

    task automatic test_single_word();
        msg.delete();
        msg.push_back(64'h0000_0000_00CC_BBAA);
        run_msg(3, 4);
        n_tests++;
        if (obs.size() != 1 || obs[0][63:0] !== 64'h0000_0000_40CC_BBAA || obs[0][64*R-1:64] !== '0) begin
            n_fail++;
            $display("FAIL single_word: n=%0d w0=%h want 1 block w0=0000000040ccbbaa", obs.size(), obs.size() ? obs[0][63:0] : 64'h0);
        end
    endtask

    task automatic test_pad_next_slot();
        msg.delete();
        for (int i = 0; i < 5; i++) msg.push_back(rnd64());
        run_msg(0, 3);
        n_tests++;
        if (obs.size() != 1 || obs[0][64*5 +: 64] !== 64'h40 || obs[0][64*R-1:64*6] !== '0) begin
            n_fail++;
            $display("FAIL pad_next_slot: n=%0d w5=%h want 1 block w5=40", obs.size(), obs.size() ? obs[0][64*5 +: 64] : 64'h0);
        end
    endtask

    task automatic test_block_boundary();
        logic [64*R-1:0] pad_blk;
        pad_blk = '0;
        pad_blk[63:0] = 64'h40;
        msg.delete();
        for (int i = 0; i < R; i++) msg.push_back(rnd64());
        run_msg(0, 5);
        n_tests++;
        if (obs.size() != 2 || obs[1] !== pad_blk || obs[0][64*(R-1) +: 64] !== msg[R-1]) begin
            n_fail++;
            $display("FAIL block_boundary: n=%0d blk1_w0=%h want 2 blocks, pad-only second", obs.size(), obs.size() > 1 ? obs[1][63:0] : 64'h0);
        end
    endtask

    task automatic test_back_to_back();
        msg.delete();
        for (int i = 0; i < R + 1; i++) msg.push_back(rnd64());
        run_msg(0, 6);
        n_tests++;
        if (obs.size() != 2 || obs[1][63:0] !== msg[R] || obs[1][127:64] !== 64'h40) begin
            n_fail++;
            $display("FAIL back_to_back: n=%0d w0=%h w1=%h want data,40", obs.size(),
                     obs.size() > 1 ? obs[1][63:0] : 64'h0, obs.size() > 1 ? obs[1][127:64] : 64'h0);
        end
    endtask

    task automatic test_random_lengths();
        for (int m = 0; m < 6; m++) begin
            int n;
            n = $urandom_range(1, 3 * R);
            msg.delete();
            for (int i = 0; i < n; i++) msg.push_back(rnd64());
            run_msg($urandom_range(0, 7), $urandom_range(1, 8));
        end
    endtask

    task automatic test_reset_wait();
        int s0, d0, t;
        msg.delete();
        for (int i = 0; i < R; i++) msg.push_back(rnd64());
        cu_lat = 20;
        begin
            int nb;
            push_expected(0, nb);
        end
        s0 = n_start;
        send_msg(0);
        t = 0;
        while (n_start == s0 && t < 100) begin @(negedge clk); t++; end
        n_tests++;
        if (n_start == s0) begin
            n_fail++; $display("FAIL rst_wait_start: no start seen, want 1");
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        n_tests++;
        if (blk_data !== '0 || blk_last !== 1'b0 || msg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wait_clear: data_nz=%b last=%b ready=%b want 0", |blk_data, blk_last, msg_ready);
        end
        s0 = n_start; d0 = n_done;
        repeat (40) @(negedge clk);
        n_tests++;
        if (n_start != s0 || n_done != d0) begin
            n_fail++;
            $display("FAIL rst_wait_quiet: starts=%0d dones=%0d want 0 0", n_start - s0, n_done - d0);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_pad_next_slot();
        test_block_boundary();
        test_back_to_back();
        test_random_lengths();
        test_reset_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
